io_timer_bank: RTL
==================

# io_timer_bank

Parametrised bank of memory-mapped countdown timers on the CPU IO bus. It replaces the single fixed timer channel in the IO subsystem and adds:
- a per-channel prescaler
- one-shot and auto-reload modes
- per-channel interrupt enable
- write-1-to-clear pending flags
- a combined active-low interrupt line.

It decodes its own address window within the IO select region. It drives read data onto the IO read mux.

## Interface
Parameters:
- NUM_TIMERS, 4, number of timer channels (1..8)
- COUNT_WIDTH, 32, width of LOAD/COUNT registers (8..32)
- PRESCALE_WIDTH, 8, width of CTRL.prescale field (1..16)
- BASE_OFFSET, 16'h0100, window base compared against Address[15:0] (16-byte aligned)

Ports:
- Clock  in  1  system clock; sole clock
- Reset  in  1  synchronous, active-high reset
- IO_Select  in  1  IO region select from top-level decoder
- AS_L  in  1  address strobe, active low
- WE_L  in  1  0 = write, 1 = read
- Address  in  32  byte address; only [15:0] decoded
- IO_data_in  in  32  write data
- byte_enable  in  4  byte lanes for writes to LOAD and CTRL
- IO_data_out  out  32  read data; 0 when not a selected read of a mapped register
- irq_vector  out  NUM_TIMERS  per-channel (pending & irq_en)
- IRQ_L  out  1  active-low OR of irq_vector

## Operation
- **Channel i registers.** Channel i occupies BASE_OFFSET + 16·i:
  - +0x0 LOAD (RW)
  - +0x4 COUNT (RO)
  - +0x8 CTRL (RW): bit0 en, bit1 auto_reload, bit2 irq_en, bits[8+PRESCALE_WIDTH-1:8] prescale
  - +0xC STATUS (bit0 pending; read returns pending, write 1 clears it)
- **IRQ summary.** BASE_OFFSET + 0xF0 is IRQ_SUMMARY (RO). Bits[NUM_TIMERS-1:0] are the pending flags of all channels.
- **Access qualification.** Access = IO_Select & !AS_L & Address[15:0] matches a mapped register.
  - A write when WE_L = 0.
  - A read when WE_L = 1.
- **Unmapped addresses.** Unmapped offsets read 0. Writes to them are ignored. Writes to COUNT and IRQ_SUMMARY are ignored.
- **Strobe length.** Writes take effect on every cycle the strobe holds. All write effects are idempotent, so a multi-cycle strobe equals a single write.
- **Byte lanes.** LOAD and CTRL honour byte_enable per byte lane. Bits above the register width are ignored on write and read as 0. STATUS acts on IO_data_in[0] only if byte_enable[0] = 1.
- **Reads.** IO_data_out is combinational from the current register contents.
- **Per-channel state.** LOAD, COUNT, CTRL, pending, and a prescale counter pc of PRESCALE_WIDTH bits.
- **Enable edge.** A write that makes en go 0→1 sets COUNT <= LOAD (new LOAD if written in the same cycle) and pc <= 0.
- **Disable.** A write that clears en freezes COUNT and sets pc <= 0.
- **Tick.** When en = 1:
  - If pc == prescale: pc <= 0 and a tick occurs.
  - Otherwise pc <= pc + 1.
- **On tick, COUNT != 0.** COUNT <= COUNT − 1.
- **On tick, COUNT == 0 (expiry).** pending <= 1, then:
  - auto_reload = 1: COUNT <= LOAD.
  - auto_reload = 0: en <= 0 and COUNT stays 0.
- **Period.** (LOAD+1)·(prescale+1) cycles. LOAD = 0 with auto_reload expires every tick.
- **Writing LOAD while running.** Does not disturb COUNT. It takes effect at the next reload or enable edge.
- **Simultaneous expiry and W1C of pending.** Set wins; pending stays 1.
- **Simultaneous expiry and a CTRL write clearing en.** The write wins for en; pending is still set.
- **Interrupt outputs.**
  - irq_vector[i] = pending[i] & irq_en[i].
  - IRQ_L = ~|irq_vector.
  - Pending sets regardless of irq_en.

## Timing
- **Reset** (synchronous, Reset high at a Clock edge):
  - LOAD, COUNT, CTRL, pc and pending all 0.
  - irq_vector = 0, IRQ_L = 1.
  - IO_data_out = 0 unless a read is in progress.
- **Reset mid-count.** Reset overrides any concurrent write or tick. Timers are stopped afterwards.
- **Write latency.** A register write is visible at the next Clock edge. A read in the following cycle returns the new value.
- **Read latency.** 0 cycles (combinational), same as other IO devices.
- **Example.** LOAD = 3, prescale = 0, en written at edge E:
  - Edge E: COUNT = 3.
  - Edges E+1..E+3: COUNT = 2, 1, 0.
  - Edge E+4: pending = 1 and IRQ_L low after E+4 (if irq_en).
  - With auto_reload, COUNT = 3 at E+4.
- **Interrupt latency.** irq_vector/IRQ_L change combinationally from registered pending and irq_en, i.e. at most 0 cycles after the edge that sets or clears them.
- **Pending clear.** A W1C of pending at edge C deasserts IRQ_L after C, unless expiry occurs at C.

## Test plan
- **Reset values.** Assert Reset mid-run with channel 0 counting → after the edge, all registers read 0 and IRQ_L = 1; no expiry for 100 cycles.
- **One-shot.** Channel 1: LOAD = 5, CTRL = 0x5 (en, irq_en, prescale 0) → pending and IRQ_L = 0 exactly 6 cycles after the enabling edge; CTRL.en reads 0; COUNT reads 0; no further expiry.
- **Auto-reload with prescale.** Channel 0: LOAD = 2, CTRL = 0x0000_0303 (en, auto_reload, prescale 3) → pending sets every 12 cycles. After a W1C to STATUS, IRQ_L stays low only if irq_en = 1 (here IRQ_L = 1).
- **W1C race.** Issue STATUS write 1 on the same edge as channel 2 expiry → pending remains 1 and IRQ_SUMMARY bit2 = 1.
- **Byte enables and unmapped addresses.** Write LOAD = 0xAABBCCDD with byte_enable = 4'b0101 over prior 0 → LOAD reads 0x00BB00DD. A write to BASE+0x4 is ignored. A read at BASE + 16·NUM_TIMERS reads 0.
- **Mid-run LOAD change.** Channel 3 in auto-reload with LOAD = 10: write LOAD = 2 mid-count → current period still 11 ticks, subsequent periods 3 ticks. A read with IO_Select = 0 returns 0.

Source files
------------

// File: rtl/io_timer_bank.sv
// Bank of memory-mapped countdown timers on the CPU IO bus.
// Each channel has a prescaler, one-shot or auto-reload mode, a W1C pending flag and an interrupt enable.
module io_timer_bank #(
    parameter int          NUM_TIMERS     = 4,
    parameter int          COUNT_WIDTH    = 32,
    parameter int          PRESCALE_WIDTH = 8,
    parameter logic [15:0] BASE_OFFSET    = 16'h0100
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  IO_Select,
    input  logic                  AS_L,
    input  logic                  WE_L,
    input  logic [31:0]           Address,
    input  logic [31:0]           IO_data_in,
    input  logic [3:0]            byte_enable,
    output logic [31:0]           IO_data_out,
    output logic [NUM_TIMERS-1:0] irq_vector,
    output logic                  IRQ_L
);
    localparam logic [1:0] REG_LOAD   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [15:0] rel;
    logic        in_window, access, wr, rd, sum_sel;
    logic [3:0]  ch_idx;
    logic [1:0]  reg_idx;
    logic [31:0] lane_mask;
    logic        unused_addr_hi;

    // Offset relative to the window; addresses below the base wrap high and fall outside it.
    assign rel            = Address[15:0] - BASE_OFFSET;
    assign in_window      = (rel[15:8] == 8'h00) && (rel[1:0] == 2'b00);
    assign access         = IO_Select && !AS_L && in_window;
    assign wr             = access && !WE_L;
    assign rd             = access && WE_L;
    assign ch_idx         = rel[7:4];
    assign reg_idx        = rel[3:2];
    assign sum_sel        = (rel[7:0] == 8'hF0);
    assign lane_mask      = {{8{byte_enable[3]}}, {8{byte_enable[2]}},
                             {8{byte_enable[1]}}, {8{byte_enable[0]}}};
    assign unused_addr_hi = ^Address[31:16];

    logic [31:0]           load_img  [NUM_TIMERS];
    logic [31:0]           count_img [NUM_TIMERS];
    logic [31:0]           ctrl_img  [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] pend_vec;
    logic [NUM_TIMERS-1:0] ie_vec;

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        logic [COUNT_WIDTH-1:0]    load_q, count_q, load_w, load_n;
        logic [PRESCALE_WIDTH-1:0] ps_q, pc_q, ps_w;
        logic                      en_q, ar_q, ie_q, pend_q;
        logic                      ch_wr, load_we, ctrl_we, clr_req;
        logic                      en_w, ar_w, ie_w, en_n;
        logic                      tick, expire, en_rise, en_fall;

        assign ch_wr   = wr && (ch_idx == 4'(i));
        assign load_we = ch_wr && (reg_idx == REG_LOAD);
        assign ctrl_we = ch_wr && (reg_idx == REG_CTRL);
        assign clr_req = ch_wr && (reg_idx == REG_STATUS) && byte_enable[0] && IO_data_in[0];

        assign load_w = (load_q & ~lane_mask[COUNT_WIDTH-1:0])
                      | (IO_data_in[COUNT_WIDTH-1:0] & lane_mask[COUNT_WIDTH-1:0]);
        assign load_n = load_we ? load_w : load_q;
        assign en_w   = byte_enable[0] ? IO_data_in[0] : en_q;
        assign ar_w   = byte_enable[0] ? IO_data_in[1] : ar_q;
        assign ie_w   = byte_enable[0] ? IO_data_in[2] : ie_q;
        assign ps_w   = (ps_q & ~lane_mask[8 +: PRESCALE_WIDTH])
                      | (IO_data_in[8 +: PRESCALE_WIDTH] & lane_mask[8 +: PRESCALE_WIDTH]);

        assign tick    = en_q && (pc_q == ps_q);
        assign expire  = tick && (count_q == '0);
        assign en_rise = ctrl_we && !en_q && en_w;
        assign en_fall = ctrl_we && en_q && !en_w;
        // A CTRL write decides en even when a one-shot expiry lands on the same edge.
        assign en_n    = ctrl_we ? en_w : ((expire && !ar_q) ? 1'b0 : en_q);

        // NOTE: every state register uses <= so all channels sample the same pre-edge values.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                load_q  <= '0;
                count_q <= '0;
                ps_q    <= '0;
                pc_q    <= '0;
                en_q    <= 1'b0;
                ar_q    <= 1'b0;
                ie_q    <= 1'b0;
                pend_q  <= 1'b0;
            end else begin
                load_q <= load_n;
                en_q   <= en_n;
                if (ctrl_we) begin
                    ar_q <= ar_w;
                    ie_q <= ie_w;
                    ps_q <= ps_w;
                end
                if (en_rise) begin
                    count_q <= load_n;
                    pc_q    <= '0;
                end else if (en_fall) begin
                    pc_q    <= '0;
                end else if (en_q) begin
                    pc_q <= tick ? '0 : pc_q + 1'b1;
                    if (tick) begin
                        if (count_q != '0) count_q <= count_q - 1'b1;
                        else if (ar_q)     count_q <= load_q;
                    end
                end
                // Expiry beats a concurrent clear so no interrupt is lost.
                if (expire)       pend_q <= 1'b1;
                else if (clr_req) pend_q <= 1'b0;
            end
        end

        assign load_img[i]  = 32'(load_q);
        assign count_img[i] = 32'(count_q);
        assign ctrl_img[i]  = 32'({ps_q, 5'b00000, ie_q, ar_q, en_q});
        assign pend_vec[i]  = pend_q;
        assign ie_vec[i]    = ie_q;
    end

    // NOTE: IO_data_out is defaulted before any branch so the read mux cannot infer a latch.
    always_comb begin
        IO_data_out = '0;
        if (rd) begin
            if (sum_sel) begin
                IO_data_out = 32'(pend_vec);
            end else begin
                for (int i = 0; i < NUM_TIMERS; i++) begin
                    if (ch_idx == 4'(i)) begin
                        case (reg_idx)
                            REG_LOAD:   IO_data_out = load_img[i];
                            REG_COUNT:  IO_data_out = count_img[i];
                            REG_CTRL:   IO_data_out = ctrl_img[i];
                            REG_STATUS: IO_data_out = 32'(pend_vec[i]);
                            default:    IO_data_out = '0;
                        endcase
                    end
                end
            end
        end
    end

    assign irq_vector = pend_vec & ie_vec;
    assign IRQ_L      = ~|irq_vector;

endmodule
